// File: rtl/decoder_3to8.sv
// rtl/decoder_3to8.sv - registered 3-to-8 one-hot decoder with enable
module decoder_3to8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] A,
  output logic [7:0] D,
  output logic       valid
);

  logic [7:0] d_next;

  // An unknown select falls through to default so D can never go multi-hot.
  always_comb begin
    d_next = 8'h00;
    if (en) begin
      case (A)
        3'd0:    d_next = 8'h01;
        3'd1:    d_next = 8'h02;
        3'd2:    d_next = 8'h04;
        3'd3:    d_next = 8'h08;
        3'd4:    d_next = 8'h10;
        3'd5:    d_next = 8'h20;
        3'd6:    d_next = 8'h40;
        3'd7:    d_next = 8'h80;
        default: d_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      D     <= 8'h00;
      valid <= 1'b0;
    end else begin
      D     <= d_next;
      valid <= en;
    end
  end

endmodule

// File: tb/tb_decoder_3to8.sv
// tb/tb_decoder_3to8.sv - self-checking bench for decoder_3to8
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] A;
  logic [7:0] D;
  logic       valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_3to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .D     (D),
    .valid (valid)
  );

  // Reference: bit i is set exactly when enabled and i equals the select.
  function automatic logic [7:0] ref_decode(input logic e, input logic [2:0] sel);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      if (e && sel == 3'(i)) r[i] = 1'b1;
    return r;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic [2:0] a);
    @(negedge clk);
    rst_n = r;
    en    = e;
    A     = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 3'd5);
      checks++;
      if (D !== 8'h00 || valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: D=%h valid=%b, expected D=00 valid=0", D, valid);
      end
    end
    cycle(1'b1, 1'b1, 3'd5);
    checks++;
    if (D !== 8'h20 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: D=%h valid=%b, expected D=20 valid=1", D, valid);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] exp_d;
    for (int a = 0; a < 8; a++) begin
      exp_d = ref_decode(1'b1, 3'(a));
      for (int h = 0; h < 2; h++) begin
        cycle(1'b1, 1'b1, 3'(a));
        checks++;
        if (D !== exp_d || valid !== 1'b1 || $countones(D) != 1) begin
          errors++;
          $display("FAIL sweep A=%0d: D=%h valid=%b, expected D=%h valid=1", a, D, valid, exp_d);
        end
      end
    end
  endtask

  task automatic test_enable_gating;
    logic en_seq [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] exp_d;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, en_seq[k], 3'd3);
      exp_d = ref_decode(en_seq[k], 3'd3);
      checks++;
      if (D !== exp_d || valid !== en_seq[k]) begin
        errors++;
        $display("FAIL enable_gating step %0d: D=%h valid=%b, expected D=%h valid=%b",
                 k, D, valid, exp_d, en_seq[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] seq [4] = '{3'd7, 3'd0, 3'd7, 3'd0};
    logic [7:0] exp_d;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b1, seq[k]);
      exp_d = ref_decode(1'b1, seq[k]);
      checks++;
      if (D !== exp_d || valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back step %0d: D=%h valid=%b, expected D=%h valid=1", k, D, valid, exp_d);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic       r_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] a_seq [5] = '{3'd4, 3'd5, 3'd6, 3'd6, 3'd7};
    logic [7:0] exp_d;
    for (int k = 0; k < 5; k++) begin
      cycle(r_seq[k], 1'b1, a_seq[k]);
      exp_d = r_seq[k] ? ref_decode(1'b1, a_seq[k]) : 8'h00;
      checks++;
      if (D !== exp_d || valid !== r_seq[k]) begin
        errors++;
        $display("FAIL mid_reset step %0d: D=%h valid=%b, expected D=%h valid=%b",
                 k, D, valid, exp_d, r_seq[k]);
      end
    end
  endtask

  task automatic test_registration;
    cycle(1'b1, 1'b1, 3'd1);
    #2;
    A = 3'd6;
    #1;
    checks++;
    if (D !== 8'h02 || valid !== 1'b1) begin
      errors++;
      $display("FAIL registration_hold: D=%h valid=%b, expected D=02 valid=1", D, valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (D !== 8'h40) begin
      errors++;
      $display("FAIL registration_update: D=%h, expected D=40", D);
    end
  endtask

  task automatic test_random;
    logic       r;
    logic       e;
    logic [2:0] a;
    logic [7:0] exp_d;
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(0, 15) != 0);
      e = ($urandom_range(0, 3) != 0);
      a = 3'($urandom_range(0, 7));
      cycle(r, e, a);
      exp_d = r ? ref_decode(e, a) : 8'h00;
      checks++;
      if (D !== exp_d || valid !== (r & e) || $countones(D) != (valid ? 1 : 0)) begin
        errors++;
        $display("FAIL random step %0d: D=%h valid=%b, expected D=%h valid=%b", k, D, valid, exp_d, r & e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    A     = 3'd0;
    test_reset();
    test_sweep();
    test_enable_gating();
    test_back_to_back();
    test_mid_reset();
    test_registration();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_3to8.md
# decoder_3to8

Registered 3-to-8 one-hot decoder with active-high enable. Four instances, each gated by one output of a 2-to-4 decoder, form the 5-to-32 decoder. A 3-bit select `A` is decoded so exactly one bit of `D` is high, at bit index `A`, while enabled. The output is registered on the single system clock for clean timing into downstream select logic.

## Interface
Parameters:
- none. Widths are fixed: 3-bit select, 8-bit output.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `en`  input  1  decode enable. Driven by the upstream 2-to-4 stage in the 5-to-32 assembly. Tie to 1 for standalone use.
- `A`  input  3  select code, unsigned 0..7.
- `D`  output  8  registered one-hot decode; `D[i]` = 1 iff the last sampled `A` == i and the last sampled `en` == 1.
- `valid`  output  1  registered; 1 when `D` holds a decode of an enabled sample.

## Operation
- Combinational next-state: `d_next = en ? (8'b1 << A) : 8'b0`; `valid_next = en`.
- On each rising `clk` edge with `rst_n` = 1: `D <= d_next`, `valid <= valid_next`.
- Mapping: A=0 → 8'h01, 1 → 8'h02, 2 → 8'h04, 3 → 8'h08, 4 → 8'h10, 5 → 8'h20, 6 → 8'h40, 7 → 8'h80.
- Invariants:
  - `$countones(D)` is 1 when `valid` = 1, and 0 when `valid` = 0.
  - `D` is never multi-hot.
- `A` containing X/Z (simulation only): `D` must not be driven multi-hot. The implementation uses a full case with `default` → 8'h00.
- No internal state other than the `D` and `valid` registers. No FSM.

## Timing
- Latency: 1 clock. `A` and `en` sampled at edge N appear on `D` and `valid` after edge N.
- Throughput: one new decode per clock. Back-to-back changes of `A` are each reflected on consecutive cycles.
- Reset (`rst_n` = 0 at a rising edge): `D` = 8'h00 and `valid` = 0 after that edge, regardless of `en` and `A`. Reset has priority over `en`.
- Reset deasserted mid-stream: the first edge with `rst_n` = 1 loads the decode of the `A`/`en` present at that edge. No extra dead cycle.
- Reset asserted mid-operation: outputs clear at the next rising edge. The previous decode is discarded.
- Between edges, `D` and `valid` are glitch-free: driven only by flops, with no combinational path from inputs to outputs.
- `en` low for one cycle: `D` = 8'h00 and `valid` = 0 for exactly one cycle, then the decode resumes.
- Setup/hold on `A`, `en` and `rst_n` are relative to the `clk` rising edge. Stimulus changes away from the edge, e.g. a 20 ns hold with a 10 ns clock period.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with `en` = 1 and `A` = 3'd5 → `D` = 8'h00, `valid` = 0. Release reset → next edge gives `D` = 8'h20, `valid` = 1.
- Full sweep: `en` = 1, step `A` = 0,1,…,7, holding each for 20 ns → one edge after each change `D` = 8'h01, 02, 04, 08, 10, 20, 40, 80 in order, `valid` = 1 throughout, and `D` is always one-hot.
- Enable gating: `A` = 3'd3; toggle `en` 1 → 0 → 1 on successive cycles → `D` = 8'h08, then 8'h00 with `valid` = 0, then 8'h08 again.
- Back-to-back: change `A` every cycle in the sequence 7, 0, 7, 0 → `D` = 8'h80, 01, 80, 01 on consecutive cycles with 1-cycle latency.
- Mid-stream reset: during the sweep, assert `rst_n` = 0 for one cycle while `A` = 3'd6 → `D` = 8'h00 for that cycle. The next cycle decodes the current `A`.
- Output registration check: change `A` midway between clock edges → `D` is unchanged until the next rising edge.
